// File: rtl/glitch_pulse_gen.sv
// Trigger-to-glitch timing core: synchronizes the external trigger, waits a
// latched delay after the selected edge, then emits one pulse of latched width.
module glitch_pulse_gen #(
  parameter int DELAY_W     = 16,
  parameter int WIDTH_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               abort,
  input  logic               edge_sel,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] width,
  input  logic               trigger_in,
  output logic               glitch_out,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic [7:0]         shot_count
);

  localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    PULSE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               edge_sel_q, edge_sel_d;
  logic               done_q, done_d;
  logic [7:0]         shot_q, shot_d;
  logic               glitch_q, armed_q, busy_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_last;
  logic                   edge_det;

  // prev_q is one extra copy of the last sync stage, used only for edge detection
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign edge_det  = edge_sel_q ? (prev_q & ~sync_last) : (~prev_q & sync_last);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    delay_d    = delay_q;
    width_d    = width_q;
    edge_sel_d = edge_sel_q;
    done_d     = 1'b0;
    shot_d     = shot_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_d    = ARMED;
            delay_d    = delay;
            width_d    = width;
            edge_sel_d = edge_sel;
          end
        end
        ARMED: begin
          if (edge_det) begin
            if (delay_q != '0) begin
              state_d = DELAY;
              cnt_d   = CNT_W'(delay_q);
            end else if (width_q != '0) begin
              state_d = PULSE;
              cnt_d   = CNT_W'(width_q);
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
              shot_d  = shot_q + 8'd1;
            end
          end
        end
        DELAY: begin
          if (cnt_q == CNT_W'(1)) begin
            if (width_q != '0) begin
              state_d = PULSE;
              cnt_d   = CNT_W'(width_q);
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
              shot_d  = shot_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            shot_d  = shot_q + 8'd1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so the glitch pin is a clean flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      delay_q    <= '0;
      width_q    <= '0;
      edge_sel_q <= 1'b0;
      done_q     <= 1'b0;
      shot_q     <= 8'd0;
      glitch_q   <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      sync_q     <= '0;
      prev_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      delay_q    <= delay_d;
      width_q    <= width_d;
      edge_sel_q <= edge_sel_d;
      done_q     <= done_d;
      shot_q     <= shot_d;
      glitch_q   <= (state_d == PULSE);
      armed_q    <= (state_d == ARMED);
      busy_q     <= (state_d != IDLE);
      sync_q     <= {sync_q[SYNC_STAGES-2:0], trigger_in};
      prev_q     <= sync_last;
    end
  end

  assign glitch_out = glitch_q;
  assign armed      = armed_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign shot_count = shot_q;

endmodule
